// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_timing_gen                                                  |
// | Brief    : VGA raster timing generator with h/v counters, sync/de decode,  |
// |            pixel coordinates, line/frame pulses and a frame counter.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 29,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int CW       = 10,
   parameter int FW       = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_ce,
   output logic          h_sync,
   output logic          v_sync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          pix_valid,
   output logic          line_end,
   output logic          frame_start,
   output logic [FW-1:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] c_h_act    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] c_h_sync_s = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] c_h_sync_e = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] c_h_last   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] c_v_act    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] c_v_sync_s = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] c_v_sync_e = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] c_v_last   = CW'(V_TOTAL - 1);

   logic [CW-1:0] r_h_cnt;
   logic [CW-1:0] r_v_cnt;
   logic [FW-1:0] r_frame_cnt;

   logic          r_h_sync;
   logic          r_v_sync;
   logic          r_de;
   logic [CW-1:0] r_x;
   logic [CW-1:0] r_y;
   logic          r_pix_valid;
   logic          r_line_end;
   logic          r_frame_start;
   logic [FW-1:0] r_frame_count;

   logic w_de;
   logic w_hs_act;
   logic w_vs_act;
   logic w_h_wrap;
   logic w_v_wrap;
   logic w_frame_start;

   assign w_de          = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
   assign w_hs_act      = (r_h_cnt >= c_h_sync_s) && (r_h_cnt < c_h_sync_e);
   assign w_vs_act      = (r_v_cnt >= c_v_sync_s) && (r_v_cnt < c_v_sync_e);
   assign w_h_wrap      = (r_h_cnt == c_h_last);
   assign w_v_wrap      = (r_v_cnt == c_v_last);
   assign w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

   // Frame counter runs one pixel ahead of its output copy so the visible
   // count changes together with frame_start rather than on the last pixel.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_frame_cnt   <= '0;
         r_h_sync      <= ~H_POL;
         r_v_sync      <= ~V_POL;
         r_de          <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_pix_valid   <= 1'b0;
         r_line_end    <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_pix_valid   <= pix_ce;
         r_line_end    <= pix_ce & w_h_wrap;
         r_frame_start <= pix_ce & w_frame_start;
         if (pix_ce) begin
            r_h_sync      <= w_hs_act ? H_POL : ~H_POL;
            r_v_sync      <= w_vs_act ? V_POL : ~V_POL;
            r_de          <= w_de;
            r_x           <= r_h_cnt;
            r_y           <= r_v_cnt;
            r_frame_count <= r_frame_cnt;
            if (w_h_wrap) begin
               r_h_cnt <= '0;
               if (w_v_wrap) begin
                  r_v_cnt     <= '0;
                  r_frame_cnt <= r_frame_cnt + 1'b1;
               end else begin
                  r_v_cnt <= r_v_cnt + 1'b1;
               end
            end else begin
               r_h_cnt <= r_h_cnt + 1'b1;
            end
         end
      end
   end

   assign h_sync      = r_h_sync;
   assign v_sync      = r_v_sync;
   assign de          = r_de;
   assign x           = r_x;
   assign y           = r_y;
   assign pix_valid   = r_pix_valid;
   assign line_end    = r_line_end;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;

endmodule
`default_nettype wire
